wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage and a long-latency result source (multi-cycle MUL/DIV unit). The pipeline always has priority. Deferred long-latency results are buffered in a small FIFO and drained into idle writeback slots. A forced-stall request stops the pipeline when a buffered result has waited too long. The block sits between the W stage and the register file write port.

## Interface
- `DEPTH`, 2: pending-result FIFO entries (power of 2, ≥2)
- `MAX_WAIT`, 4: cycles a FIFO head may wait before stall is forced (1..15)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `regwriteW`  in  1  pipeline W-stage write enable
- `rdW`  in  5  pipeline destination register
- `resultW`  in  32  pipeline writeback data
- `lu_valid`  in  1  long-latency result valid
- `lu_rd`  in  5  long-latency destination register
- `lu_data`  in  32  long-latency result
- `lu_ready`  out  1  arbiter accepts `lu_*` this cycle
- `rf_we`  out  1  register-file write enable
- `rf_rd`  out  5  register-file write address
- `rf_wd`  out  32  register-file write data
- `stall_req`  out  1  request a pipeline freeze (registered)
- `pending`  out  1  FIFO non-empty

## Operation
- The long-latency transfer completes on a clock edge with `lu_valid & lu_ready`. `lu_ready = !full`, so it is 1 out of reset.
- A pipeline slot is "busy" when `regwriteW=1` and `rdW!=0`.
- Port select, in priority order:
  1. Busy pipeline slot: `rf_* <= {1, rdW, resultW}`.
  2. FIFO non-empty: write the head, then pop the head at the edge.
  3. Otherwise: `rf_we=0`.
- Writes to x0 are never issued. `lu_rd=0` is accepted and discarded (no push).
- Push and pop in the same cycle is legal. When full, a pop in that cycle does not raise `lu_ready` combinationally.
- Issue logic guarantees no WAW conflict between buffered and pipeline results. The arbiter does not check for it.
- FSM `st`:
  - `IDLE`: FIFO empty. A push moves to `PEND`.
  - `PEND`: FIFO non-empty.
    - A pop that empties the FIFO with no push moves to `IDLE`.
    - `age` reaching `MAX_WAIT` moves to `FORCE`.
  - `FORCE`: `stall_req=1`. Stay until the head is written, then go to `PEND`, or to `IDLE` if the FIFO is empty.
- `age` (4-bit):
  - Clears on every pop and on entry to `IDLE`.
  - Increments each cycle in `PEND` that has no pop.
  - Saturates at `MAX_WAIT`.
- FIFO pointers are `$clog2(DEPTH)+1` bits, with wrap via the MSB. Full means the indices are equal and the MSBs differ.

## Timing
- `rf_*` are combinational from the inputs and FIFO head. The register file writes on the same edge.
- Buffered path latency: accept at edge N, earliest write in cycle N+1.
- `stall_req` is asserted the cycle after `age` reaches `MAX_WAIT`. During the stall the pipeline drives `regwriteW=0`, so the head drains that cycle and `stall_req` drops the following cycle.
- Reset mid-operation: FIFO contents are discarded, and pointers and `age` are cleared. State goes to `IDLE`.
- Reset values: `rf_we=0`, `rf_rd=0`, `rf_wd=0`, `stall_req=0`, `pending=0`, `lu_ready=1`.

## Configuration
- `WB_BYPASS_EN` defined:
  - Applies when the FIFO is empty, the pipeline slot is free and `lu_valid=1` with `lu_rd!=0`.
  - `lu_*` is written directly to the port in the same cycle, with no push and zero added latency.
- `WB_BYPASS_EN` undefined: every long-latency result passes through the FIFO, so minimum latency is one cycle.

## Structure
- Shared package `wb_pkg` holds:
  - the `wb_state_t` enum (`IDLE`, `PEND`, `FORCE`)
  - the `XLEN=32` and `REG_AW=5` constants
  - the `wb_req_t` struct {rd, data}
- One sub-module: `wb_fifo` (parameterised sync FIFO with async reset; push/pop/full/empty/head).
- The arbiter top holds the select mux, the FSM and the age counter.

## Test plan
- **Reset**: assert `rst` mid-burst with 2 entries pending → all outputs take their reset values immediately. After release, `lu_ready=1` and `pending=0`.
- **Pipeline priority**: `regwriteW=1`, `rdW=5`, `resultW=0x22222222` with `lu_valid=1`, `lu_rd=7`, `lu_data=0xAAAA0000` → `rf_rd=5`. The x7 write lands on the first free cycle.
- **Full FIFO**:
  - Keep `regwriteW=1` continuously and push 2 results → `lu_ready=0`.
  - Drop `regwriteW` → both drain in order, and `lu_ready` returns to 1 one cycle after the first pop.
- **Forced stall**: one entry with `MAX_WAIT=4` and a continuously busy pipeline → `stall_req=1` on cycle 5 after the push. The head is written when `regwriteW=0`, and `stall_req` is 0 the next cycle.
- **x0 filtering**: `regwriteW=1`, `rdW=0` → `rf_we=0`, or the FIFO head is written if one is pending. `lu_rd=0` causes no push.
- **Bypass**:
  - With `WB_BYPASS_EN`: empty FIFO, idle pipeline, `lu_rd=3` → `rf_we=1`, `rf_rd=3` in the same cycle.
  - Without `WB_BYPASS_EN`: the same stimulus gives `rf_we=1` one cycle later.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } wb_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending long-latency results with asynchronous active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_req_t                wdata_i,
    output wb_req_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    wb_req_t     mem_q [Depth];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + PtrOne;
            if (pop_i && !empty_o) rd_q <= rd_q + PtrOne;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline W stage has priority, long-latency results
// queue in wb_fifo and drain into idle slots. WB_BYPASS_EN enables same-cycle direct writes.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwriteW,
    input  logic [REG_AW-1:0] rdW,
    input  logic [XLEN-1:0]   resultW,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wd,
    output logic              stall_req,
    output logic              pending
);
    localparam int unsigned     CntW    = $clog2(DEPTH) + 1;
    localparam logic [3:0]      MaxAge  = 4'(MAX_WAIT);
    localparam logic [CntW-1:0] OneLeft = CntW'(1);

    logic            busy;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CntW-1:0] count;
    wb_req_t         head;
    wb_req_t         lu_req;
    wb_state_t       st;
    logic [3:0]      age;
    logic            stall_q;

    assign busy        = regwriteW && (rdW != '0);
    assign lu_req.rd   = lu_rd;
    assign lu_req.data = lu_data;

`ifdef WB_BYPASS_EN
    assign bypass = empty && !busy && lu_valid && (lu_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // Readiness looks only at the current fill level, never at a same-cycle pop.
    assign lu_ready  = !full;
    assign push      = lu_valid && !full && (lu_rd != '0) && !bypass;
    assign pop       = !busy && !empty;
    assign pending   = !empty;
    assign stall_req = stall_q;

    wb_fifo #(
        .Depth(DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(lu_req),
        .head_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_rd = '0;
        rf_wd = '0;
        if (!rst) begin
            if (busy) begin
                rf_we = 1'b1;
                rf_rd = rdW;
                rf_wd = resultW;
            end else if (!empty) begin
                rf_we = 1'b1;
                rf_rd = head.rd;
                rf_wd = head.data;
            end else if (bypass) begin
                rf_we = 1'b1;
                rf_rd = lu_rd;
                rf_wd = lu_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            age     <= '0;
            stall_q <= 1'b0;
        end else begin
            unique case (st)
                IDLE: begin
                    age <= '0;
                    if (push) st <= PEND;
                end
                PEND: begin
                    if (pop) begin
                        age <= '0;
                        if (count == OneLeft && !push) st <= IDLE;
                    end else if (age == MaxAge) begin
                        st      <= FORCE;
                        stall_q <= 1'b1;
                    end else begin
                        age <= age + 4'd1;
                    end
                end
                FORCE: begin
                    if (pop) begin
                        age     <= '0;
                        stall_q <= 1'b0;
                        st      <= (count == OneLeft && !push) ? IDLE : PEND;
                    end
                end
                default: begin
                    st      <= IDLE;
                    age     <= '0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model. Honours WB_BYPASS_EN when defined.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic        pending;

    int n_chk;
    int n_fail;

    wb_port_arbiter #(
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .regwriteW(regwriteW),
        .rdW      (rdW),
        .resultW  (resultW),
        .lu_valid (lu_valid),
        .lu_rd    (lu_rd),
        .lu_data  (lu_data),
        .lu_ready (lu_ready),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_wd    (rf_wd),
        .stall_req(stall_req),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        regwriteW = rw;
        rdW       = rd;
        resultW   = res;
        lu_valid  = lv;
        lu_rd     = lrd;
        lu_data   = ld;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({rf_we, rf_rd, rf_wd} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_rf got %h expected 0", {rf_we, rf_rd, rf_wd});
        end
        n_chk++;
        if ({lu_ready, pending, stall_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_status got %b expected 100", {lu_ready, pending, stall_req});
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd4, 32'hDEAD0001);
        next_cycle();
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd4, 32'hDEAD0002);
        next_cycle();
        drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_chk++;
        if ({lu_ready, pending} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_burst_full got %b expected 01", {lu_ready, pending});
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({rf_we, rf_rd, rf_wd} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_mid_rf got %h expected 0", {rf_we, rf_rd, rf_wd});
        end
        n_chk++;
        if ({lu_ready, pending, stall_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_status got %b expected 100", {lu_ready, pending, stall_req});
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({lu_ready, pending, stall_req, rf_we} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_after got %b expected 1000",
                     {lu_ready, pending, stall_req, rf_we});
        end
    endtask

    task automatic test_priority();
        apply_reset();
        drive(1'b1, 5'd5, 32'h22222222, 1'b1, 5'd7, 32'hAAAA0000);
        @(negedge clk);
        n_chk++;
        if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd5, 32'h22222222}) begin
            n_fail++;
            $display("FAIL prio_pipe got %h expected %h", {rf_we, rf_rd, rf_wd},
                     {1'b1, 5'd5, 32'h22222222});
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_chk++;
        if ({rf_we, rf_rd, rf_wd, pending} !== {1'b1, 5'd7, 32'hAAAA0000, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_deferred got %h expected %h", {rf_we, rf_rd, rf_wd, pending},
                     {1'b1, 5'd7, 32'hAAAA0000, 1'b1});
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({rf_we, pending} !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_drained got %b expected 00", {rf_we, pending});
        end
    endtask

    task automatic test_full();
        apply_reset();
        drive(1'b1, 5'd10, 32'h10101010, 1'b1, 5'd11, 32'hD1D1D1D1);
        next_cycle();
        drive(1'b1, 5'd10, 32'h10101010, 1'b1, 5'd12, 32'hD2D2D2D2);
        next_cycle();
        drive(1'b1, 5'd10, 32'h10101010, 1'b1, 5'd13, 32'hD3D3D3D3);
        @(negedge clk);
        n_chk++;
        if ({lu_ready, pending, stall_req, rf_rd} !== {3'b010, 5'd10}) begin
            n_fail++;
            $display("FAIL full_status got %h expected %h",
                     {lu_ready, pending, stall_req, rf_rd}, {3'b010, 5'd10});
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_chk++;
        if ({rf_we, rf_rd, rf_wd, lu_ready} !== {1'b1, 5'd11, 32'hD1D1D1D1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_first got %h expected %h", {rf_we, rf_rd, rf_wd, lu_ready},
                     {1'b1, 5'd11, 32'hD1D1D1D1, 1'b0});
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({rf_we, rf_rd, rf_wd, lu_ready} !== {1'b1, 5'd12, 32'hD2D2D2D2, 1'b1}) begin
            n_fail++;
            $display("FAIL full_second got %h expected %h", {rf_we, rf_rd, rf_wd, lu_ready},
                     {1'b1, 5'd12, 32'hD2D2D2D2, 1'b1});
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({rf_we, pending} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_empty got %b expected 00", {rf_we, pending});
        end
    endtask

    task automatic test_stall();
        apply_reset();
        drive(1'b1, 5'd2, 32'h20202020, 1'b1, 5'd6, 32'h66666666);
        next_cycle();
        drive(1'b1, 5'd2, 32'h20202020, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            n_chk++;
            if (stall_req !== (k == 5)) begin
                n_fail++;
                $display("FAIL stall_cycle%0d got %b expected %b", k, stall_req, (k == 5));
            end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        n_chk++;
        if ({rf_we, rf_rd, rf_wd, stall_req} !== {1'b1, 5'd6, 32'h66666666, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_drain got %h expected %h", {rf_we, rf_rd, rf_wd, stall_req},
                     {1'b1, 5'd6, 32'h66666666, 1'b1});
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({stall_req, pending} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_release got %b expected 00", {stall_req, pending});
        end
    endtask

    task automatic test_x0();
        apply_reset();
        drive(1'b1, 5'd0, 32'hBADBAD00, 1'b1, 5'd0, 32'hBADBAD01);
        @(negedge clk);
        n_chk++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_pipe_we got %b expected 0", rf_we);
        end
        next_cycle();
        drive(1'b1, 5'd9, 32'h90909090, 1'b1, 5'd8, 32'h88888888);
        @(negedge clk);
        n_chk++;
        if (pending !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_lu_nopush got %b expected 0", pending);
        end
        next_cycle();
        drive(1'b1, 5'd0, 32'hBADBAD02, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_chk++;
        if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd8, 32'h88888888}) begin
            n_fail++;
            $display("FAIL x0_head got %h expected %h", {rf_we, rf_rd, rf_wd},
                     {1'b1, 5'd8, 32'h88888888});
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({rf_we, pending} !== 2'b00) begin
            n_fail++;
            $display("FAIL x0_drained got %b expected 00", {rf_we, pending});
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33333333);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        n_chk++;
        if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd3, 32'h33333333}) begin
            n_fail++;
            $display("FAIL bypass_same got %h expected %h", {rf_we, rf_rd, rf_wd},
                     {1'b1, 5'd3, 32'h33333333});
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_chk++;
        if ({rf_we, pending} !== 2'b00) begin
            n_fail++;
            $display("FAIL bypass_nopush got %b expected 00", {rf_we, pending});
        end
`else
        n_chk++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL nobypass_same got %b expected 0", rf_we);
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_chk++;
        if ({rf_we, rf_rd, rf_wd, pending} !== {1'b1, 5'd3, 32'h33333333, 1'b1}) begin
            n_fail++;
            $display("FAIL nobypass_next got %h expected %h", {rf_we, rf_rd, rf_wd, pending},
                     {1'b1, 5'd3, 32'h33333333, 1'b1});
        end
`endif
    endtask

    // Reference: a queue of deferred results plus a count of cycles the head has waited.
    task automatic test_random();
        wb_req_t     q[$];
        int          waited;
        bit          stall;
        bit          busy;
        bit          byp;
        bit          popm;
        bit          pushm;
        logic        rw;
        logic        lv;
        logic [4:0]  rd;
        logic [4:0]  lrd;
        logic [31:0] res;
        logic [31:0] ld;
        logic [37:0] exp_rf;
        logic [2:0]  exp_st;
        apply_reset();
        waited = 0;
        stall  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rw  = ($urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 88 : 40));
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            res = $urandom;
            lv  = ($urandom_range(0, 2) == 0);
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld  = $urandom;
            drive(rw, rd, res, lv, lrd, ld);
            busy = rw && (rd != 5'd0);
            byp  = 1'b0;
`ifdef WB_BYPASS_EN
            byp = (q.size() == 0) && !busy && lv && (lrd != 5'd0);
`endif
            if (busy) exp_rf = {1'b1, rd, res};
            else if (q.size() > 0) exp_rf = {1'b1, q[0].rd, q[0].data};
            else if (byp) exp_rf = {1'b1, lrd, ld};
            else exp_rf = '0;
            exp_st = {q.size() < DEPTH, q.size() != 0, stall};
            @(negedge clk);
            n_chk++;
            if ({rf_we, rf_rd, rf_wd} !== exp_rf) begin
                n_fail++;
                $display("FAIL rand_rf cycle %0d got %h expected %h", i,
                         {rf_we, rf_rd, rf_wd}, exp_rf);
            end
            n_chk++;
            if ({lu_ready, pending, stall_req} !== exp_st) begin
                n_fail++;
                $display("FAIL rand_status cycle %0d got %b expected %b", i,
                         {lu_ready, pending, stall_req}, exp_st);
            end
            popm  = !busy && (q.size() > 0);
            pushm = lv && (q.size() < DEPTH) && (lrd != 5'd0) && !byp;
            if (popm) begin
                waited = 0;
                stall  = 1'b0;
            end else if (q.size() > 0) begin
                if (waited >= MAX_WAIT) stall = 1'b1;
                waited++;
            end
            if (popm) void'(q.pop_front());
            if (pushm) q.push_back('{rd: lrd, data: ld});
            next_cycle();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        test_reset();
        test_priority();
        test_full();
        test_stall();
        test_x0();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
